arm_mc_datapath: RTL and testbench

- Multicycle ARM datapath. It is the consumer of the `controller` module's control outputs and the producer of its `Instr[31:12]` and `ALUFlags` inputs.
- Holds the architectural state: PC, register file R0–R14, IR, and the non-architectural Data, A, WriteData and ALUOut registers.
- Drives the unified instruction/data memory address and write data.
- Sits between the `controller` and the memory in the top-level multicycle processor.

---
 rtl/arm_mc_pkg.sv | 53 +++++
 rtl/arm_regfile.sv | 34 +++
 rtl/arm_mc_datapath.sv | 145 ++++++++++++++
 tb/tb_arm_mc_datapath.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM datapath: control-select enums,
// ALU flag bit positions and the PC register address.
package arm_mc_pkg;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [3:0] R15_ADDR = 4'd15;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_B8   = 2'b00,
    IMM_B12  = 2'b01,
    IMM_BR   = 2'b10,
    IMM_ZERO = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    SRCA_A      = 2'b00,
    SRCA_PC     = 2'b01,
    SRCA_ALUOUT = 2'b10,
    SRCA_ZERO   = 2'b11
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_WD   = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10,
    SRCB_ZERO = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_DATA   = 2'b01,
    RES_ALU    = 2'b10,
    RES_ZERO   = 2'b11
  } result_src_e;

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] sh);
    logic [63:0] d;
    d = {v, v} >> sh;
    return d[31:0];
  endfunction

endpackage

// File: rtl/arm_regfile.sv
// R0-R14 register file, two combinational read ports and one write port.
// Address 15 is not stored: reads return r15_i, writes to it are dropped.
module arm_regfile
  import arm_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3_i,
  input  logic [3:0]       ra1_i,
  input  logic [3:0]       ra2_i,
  input  logic [3:0]       wa3_i,
  input  logic [WIDTH-1:0] wd3_i,
  input  logic [WIDTH-1:0] r15_i,
  output logic [WIDTH-1:0] rd1_o,
  output logic [WIDTH-1:0] rd2_o
);

  logic [WIDTH-1:0] rf_q [15];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) rf_q[i] <= '0;
    end else if (we3_i && (wa3_i != R15_ADDR)) begin
      rf_q[wa3_i] <= wd3_i;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write returns the old value.
  assign rd1_o = (ra1_i == R15_ADDR) ? r15_i : rf_q[ra1_i];
  assign rd2_o = (ra2_i == R15_ADDR) ? r15_i : rf_q[ra2_i];

endmodule

// File: rtl/arm_mc_datapath.sv
// Multicycle ARM datapath: PC, IR, register file, staging registers and ALU.
// Define ARM_DP_ROTIMM_EN to rotate the 8-bit immediate right by 2*IR[11:8].
module arm_mc_datapath
  import arm_mc_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ReadData,
  input  logic             PCWrite,
  input  logic             RegWrite,
  input  logic             IRWrite,
  input  logic             AdrSrc,
  input  logic [1:0]       RegSrc,
  input  logic [1:0]       ALUSrcA,
  input  logic [1:0]       ALUSrcB,
  input  logic [1:0]       ResultSrc,
  input  logic [1:0]       ImmSrc,
  input  logic [1:0]       ALUControl,
  output logic [WIDTH-1:0] Adr,
  output logic [WIDTH-1:0] WriteData,
  output logic [19:0]      Instr,
  output logic [3:0]       ALUFlags
);

  logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d;
  logic [WIDTH-1:0] data_q, a_q, wd_q, alu_out_q;
  logic [WIDTH-1:0] rd1, rd2, ext_imm, src_a, src_b, b_eff, alu_result, result;
  logic [WIDTH:0]   sum;
  logic [3:0]       ra1, ra2;
  logic             alu_c, alu_v;
  alu_op_e          alu_op;

  assign alu_op = alu_op_e'(ALUControl);

  assign pc_d = PCWrite ? result : pc_q;
  assign ir_d = IRWrite ? ReadData : ir_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      data_q    <= '0;
      a_q       <= '0;
      wd_q      <= '0;
      alu_out_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      data_q    <= ReadData;
      a_q       <= rd1;
      wd_q      <= rd2;
      alu_out_q <= alu_result;
    end
  end

  assign ra1 = RegSrc[0] ? R15_ADDR : ir_q[19:16];
  assign ra2 = RegSrc[1] ? ir_q[15:12] : ir_q[3:0];

  // R15 reads return the live ALU result, which is PC+8 during decode.
  arm_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we3_i (RegWrite),
    .ra1_i (ra1),
    .ra2_i (ra2),
    .wa3_i (ir_q[15:12]),
    .wd3_i (result),
    .r15_i (alu_result),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  always_comb begin
    ext_imm = '0;
    case (imm_src_e'(ImmSrc))
`ifdef ARM_DP_ROTIMM_EN
      IMM_B8:   ext_imm = ror32({24'b0, ir_q[7:0]}, {ir_q[11:8], 1'b0});
`else
      IMM_B8:   ext_imm = {24'b0, ir_q[7:0]};
`endif
      IMM_B12:  ext_imm = {20'b0, ir_q[11:0]};
      IMM_BR:   ext_imm = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
      IMM_ZERO: ext_imm = '0;
    endcase
  end

  always_comb begin
    src_a = '0;
    case (src_a_e'(ALUSrcA))
      SRCA_A:      src_a = a_q;
      SRCA_PC:     src_a = pc_q;
      SRCA_ALUOUT: src_a = alu_out_q;
      SRCA_ZERO:   src_a = '0;
    endcase
    src_b = '0;
    case (src_b_e'(ALUSrcB))
      SRCB_WD:   src_b = wd_q;
      SRCB_IMM:  src_b = ext_imm;
      SRCB_FOUR: src_b = 32'd4;
      SRCB_ZERO: src_b = '0;
    endcase
  end

  always_comb begin
    b_eff      = (alu_op == ALU_SUB) ? ~src_b : src_b;
    sum        = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, alu_op == ALU_SUB};
    alu_result = sum[WIDTH-1:0];
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (alu_op)
      ALU_ADD, ALU_SUB: begin
        alu_c = sum[WIDTH];
        alu_v = (src_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      ALU_AND: alu_result = src_a & src_b;
      ALU_ORR: alu_result = src_a | src_b;
    endcase
  end

  always_comb begin
    ALUFlags         = '0;
    ALUFlags[FLAG_N] = alu_result[WIDTH-1];
    ALUFlags[FLAG_Z] = (alu_result == '0);
    ALUFlags[FLAG_C] = alu_c;
    ALUFlags[FLAG_V] = alu_v;
  end

  always_comb begin
    result = '0;
    case (result_src_e'(ResultSrc))
      RES_ALUOUT: result = alu_out_q;
      RES_DATA:   result = data_q;
      RES_ALU:    result = alu_result;
      RES_ZERO:   result = '0;
    endcase
  end

  assign Adr       = AdrSrc ? result : pc_q;
  assign WriteData = wd_q;
  assign Instr     = ir_q[31:12];

endmodule

// File: tb/tb_arm_mc_datapath.sv
// Directed-vector bench for arm_mc_datapath with hand-computed expectations.
module tb_arm_mc_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ReadData;
  logic        PCWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  logic [31:0] Adr, WriteData;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;

  int nvec = 0;
  int nerr = 0;

  arm_mc_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .ReadData   (ReadData),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Adr        (Adr),
    .WriteData  (WriteData),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags)
  );

  always #5 clk = ~clk;

  task automatic idle();
    PCWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0;
    RegSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00;
    ResultSrc = 2'b00; ImmSrc = 2'b00; ALUControl = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads IR, then R2 <= val through the Data path, then A <= R2 (IR[19:16] = 2).
  task automatic load_r2(input logic [31:0] ir, input logic [31:0] val);
    idle(); ReadData = ir; IRWrite = 1; tick();
    idle(); ReadData = val; tick();
    idle(); ResultSrc = 2'b01; RegWrite = 1; tick();
    idle(); tick();
  endtask

  task automatic test_reset();
    reset = 1; ReadData = 32'h0; idle();
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (Adr !== 32'h0) begin nerr++; $display("FAIL reset_adr: got %h want %h", Adr, 32'h0); end
    nvec++; if (Instr !== 20'h0) begin nerr++; $display("FAIL reset_instr: got %h want %h", Instr, 20'h0); end
    nvec++; if (WriteData !== 32'h0) begin nerr++; $display("FAIL reset_wd: got %h want %h", WriteData, 32'h0); end
    nvec++; if (ALUFlags !== 4'b0100) begin nerr++; $display("FAIL reset_flags: got %b want %b", ALUFlags, 4'b0100); end
    reset = 0;
    tick();
  endtask

  task automatic test_fetch();
    idle(); ReadData = 32'hE04F_000F; IRWrite = 1; ALUSrcA = 2'b01; ALUSrcB = 2'b10;
    ResultSrc = 2'b10; PCWrite = 1;
    #1;
    nvec++; if (Adr !== 32'h0) begin nerr++; $display("FAIL fetch_adr: got %h want %h", Adr, 32'h0); end
    nvec++; if (ALUFlags !== 4'b0000) begin nerr++; $display("FAIL fetch_flags: got %b want %b", ALUFlags, 4'b0000); end
    tick();
    idle(); #1;
    nvec++; if (Instr !== 20'hE04F0) begin nerr++; $display("FAIL fetch_instr: got %h want %h", Instr, 20'hE04F0); end
    nvec++; if (Adr !== 32'h4) begin nerr++; $display("FAIL fetch_pc: got %h want %h", Adr, 32'h4); end
  endtask

  task automatic test_sub_r15();
    idle(); RegSrc = 2'b01; ALUSrcA = 2'b01; ALUSrcB = 2'b10; tick();
    nvec++; if (WriteData !== 32'h8) begin nerr++; $display("FAIL decode_r15: got %h want %h", WriteData, 32'h8); end
    idle(); ALUControl = 2'b01; #1;
    nvec++; if (ALUFlags !== 4'b0110) begin nerr++; $display("FAIL sub_flags: got %b want %b", ALUFlags, 4'b0110); end
    tick();
    idle(); RegWrite = 1; AdrSrc = 1; #1;
    nvec++; if (Adr !== 32'h0) begin nerr++; $display("FAIL sub_result: got %h want %h", Adr, 32'h0); end
    tick();
  endtask

  task automatic test_add_imm();
    idle(); ReadData = 32'hE280_2005; IRWrite = 1; tick();
    idle(); tick();
    idle(); ALUSrcB = 2'b01; AdrSrc = 1; ResultSrc = 2'b10; #1;
    nvec++; if (ALUFlags !== 4'b0000) begin nerr++; $display("FAIL add_flags: got %b want %b", ALUFlags, 4'b0000); end
    nvec++; if (Adr !== 32'h5) begin nerr++; $display("FAIL add_result: got %h want %h", Adr, 32'h5); end
    tick();
    // Writeback also loads PC: both writes land on the same edge.
    idle(); RegWrite = 1; PCWrite = 1; RegSrc = 2'b10; AdrSrc = 1; #1;
    nvec++; if (Adr !== 32'h5) begin nerr++; $display("FAIL add_wb: got %h want %h", Adr, 32'h5); end
    tick();
    nvec++; if (WriteData !== 32'h0) begin nerr++; $display("FAIL same_cycle_old: got %h want %h", WriteData, 32'h0); end
    idle(); RegSrc = 2'b10; tick();
    nvec++; if (WriteData !== 32'h5) begin nerr++; $display("FAIL r2_readback: got %h want %h", WriteData, 32'h5); end
    idle(); #1;
    nvec++; if (Adr !== 32'h5) begin nerr++; $display("FAIL pc_with_regwrite: got %h want %h", Adr, 32'h5); end
  endtask

  task automatic test_alu_edges();
    load_r2(32'hE282_2001, 32'h7FFF_FFFF);
    idle(); ALUSrcB = 2'b01; AdrSrc = 1; ResultSrc = 2'b10; #1;
    nvec++; if (ALUFlags !== 4'b1001) begin nerr++; $display("FAIL ovf_flags: got %b want %b", ALUFlags, 4'b1001); end
    nvec++; if (Adr !== 32'h8000_0000) begin nerr++; $display("FAIL ovf_result: got %h want %h", Adr, 32'h8000_0000); end
    load_r2(32'hE202_200F, 32'h0000_00F0);
    idle(); ALUSrcB = 2'b01; ALUControl = 2'b10; AdrSrc = 1; ResultSrc = 2'b10; #1;
    nvec++; if (ALUFlags !== 4'b0100) begin nerr++; $display("FAIL and_flags: got %b want %b", ALUFlags, 4'b0100); end
    nvec++; if (Adr !== 32'h0) begin nerr++; $display("FAIL and_result: got %h want %h", Adr, 32'h0); end
    ALUControl = 2'b11; #1;
    nvec++; if (ALUFlags !== 4'b0000) begin nerr++; $display("FAIL orr_flags: got %b want %b", ALUFlags, 4'b0000); end
    nvec++; if (Adr !== 32'hFF) begin nerr++; $display("FAIL orr_result: got %h want %h", Adr, 32'hFF); end
  endtask

  task automatic test_branch();
    idle(); ReadData = 32'hEAFF_FFFE; IRWrite = 1; tick();
    idle(); ImmSrc = 2'b10; ALUSrcA = 2'b11; ALUSrcB = 2'b01; AdrSrc = 1; ResultSrc = 2'b10; #1;
    nvec++; if (Adr !== 32'hFFFF_FFF8) begin nerr++; $display("FAIL br_extimm: got %h want %h", Adr, 32'hFFFF_FFF8); end
    nvec++; if (ALUFlags !== 4'b1000) begin nerr++; $display("FAIL br_imm_flags: got %b want %b", ALUFlags, 4'b1000); end
    idle(); ALUSrcA = 2'b11; ALUSrcB = 2'b10; tick();
    idle(); ALUSrcA = 2'b10; ALUSrcB = 2'b10; tick();
    idle(); ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = 2'b10; ResultSrc = 2'b10; PCWrite = 1; #1;
    nvec++; if (ALUFlags !== 4'b0110) begin nerr++; $display("FAIL br_flags: got %b want %b", ALUFlags, 4'b0110); end
    tick();
    idle(); #1;
    nvec++; if (Adr !== 32'h0) begin nerr++; $display("FAIL br_pc: got %h want %h", Adr, 32'h0); end
    // IR[15:12] = 15 here, so this register write must be dropped.
    idle(); ReadData = 32'hDEAD_BEEF; tick();
    idle(); ResultSrc = 2'b01; RegWrite = 1; tick();
    idle(); tick();
    nvec++; if (Adr !== 32'h0) begin nerr++; $display("FAIL r15_pc_kept: got %h want %h", Adr, 32'h0); end
    nvec++; if (WriteData !== 32'h0) begin nerr++; $display("FAIL r15_rf_kept: got %h want %h", WriteData, 32'h0); end
  endtask

  task automatic test_mid_reset();
    idle(); ALUSrcA = 2'b11; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1; tick();
    idle(); #1;
    nvec++; if (Adr !== 32'h4) begin nerr++; $display("FAIL pre_reset_pc: got %h want %h", Adr, 32'h4); end
    ResultSrc = 2'b01; RegWrite = 1; ReadData = 32'h1234_5678;
    #2 reset = 1;
    #1;
    nvec++; if (Adr !== 32'h0) begin nerr++; $display("FAIL async_pc: got %h want %h", Adr, 32'h0); end
    nvec++; if (WriteData !== 32'h0) begin nerr++; $display("FAIL async_wd: got %h want %h", WriteData, 32'h0); end
    nvec++; if (Instr !== 20'h0) begin nerr++; $display("FAIL async_instr: got %h want %h", Instr, 20'h0); end
    idle(); tick();
    reset = 0;
    idle(); ReadData = 32'h0000_0002; IRWrite = 1; tick();
    idle(); tick();
    nvec++; if (WriteData !== 32'h0) begin nerr++; $display("FAIL r2_cleared: got %h want %h", WriteData, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_sub_r15();
    test_add_imm();
    test_alu_edges();
    test_branch();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
